// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the GPR write port between EXU (port 0) and LSU (port 1),
// with a per-register busy scoreboard for decode RAW-hazard stalls.
module gpr_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issueValid,
    input  logic [AW-1:0]   issueRd,
    input  logic [AW-1:0]   rs1Addr,
    input  logic [AW-1:0]   rs2Addr,
    output logic            rs1Busy,
    output logic            rs2Busy,
    input  logic            req0Valid,
    input  logic [AW-1:0]   req0Addr,
    input  logic [XLEN-1:0] req0Data,
    output logic            req0Ready,
    input  logic            req1Valid,
    input  logic [AW-1:0]   req1Addr,
    input  logic [XLEN-1:0] req1Data,
    output logic            req1Ready,
    output logic            wen,
    output logic [AW-1:0]   wAddr,
    output logic [XLEN-1:0] wData
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            last_grant_q, last_grant_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            grant0_s, grant1_s, xfer_s;
    logic [AW-1:0]   acc_addr_s;
    logic [XLEN-1:0] acc_data_s;

    // Round-robin grant: with both valid, the port that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0Valid && req1Valid) begin
            if (last_grant_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0Valid) begin
            grant0_s = 1'b1;
        end else if (req1Valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0Ready  = grant0_s;
    assign req1Ready  = grant1_s;
    assign xfer_s     = grant0_s | grant1_s;
    assign acc_addr_s = grant1_s ? req1Addr : req0Addr;
    assign acc_data_s = grant1_s ? req1Data : req0Data;

    // Next-state for scoreboard, grant history and output stage; issue set overrides accept clear.
    always_comb begin
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (xfer_s) begin
            busy_d[acc_addr_s] = 1'b0;
            last_grant_d       = grant1_s;
            wen_d              = (acc_addr_s != {AW{1'b0}});
            waddr_d            = acc_addr_s;
            wdata_d            = acc_data_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (issueValid && (issueRd != {AW{1'b0}})) begin
            busy_d[issueRd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset; a transfer in the reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q       <= {NREG{1'b0}};
            last_grant_q <= 1'b1;
            wen_q        <= 1'b0;
            waddr_q      <= {AW{1'b0}};
            wdata_q      <= {XLEN{1'b0}};
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign rs1Busy = busy_q[rs1Addr] & (rs1Addr != {AW{1'b0}});
    assign rs2Busy = busy_q[rs2Addr] & (rs2Addr != {AW{1'b0}});
    assign wen     = wen_q;
    assign wAddr   = waddr_q;
    assign wData   = wdata_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed vector table plus randomized run against a behavioural scoreboard/arbiter model.
module tb_gpr_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            issueValid;
    logic [AW-1:0]   issueRd, rs1Addr, rs2Addr;
    logic            rs1Busy, rs2Busy;
    logic            req0Valid, req1Valid, req0Ready, req1Ready;
    logic [AW-1:0]   req0Addr, req1Addr;
    logic [XLEN-1:0] req0Data, req1Data;
    logic            wen;
    logic [AW-1:0]   wAddr;
    logic [XLEN-1:0] wData;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    gpr_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .issueValid(issueValid), .issueRd(issueRd),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
        .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Data(req0Data), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Data(req1Data), .req1Ready(req1Ready),
        .wen(wen), .wAddr(wAddr), .wData(wData)
    );

    typedef struct {
        logic            rst;
        logic            iv;
        logic [AW-1:0]   ird, rs1, rs2;
        logic            r0v;
        logic [AW-1:0]   r0a;
        logic [XLEN-1:0] r0d;
        logic            r1v;
        logic [AW-1:0]   r1a;
        logic [XLEN-1:0] r1d;
        logic            e_r0rdy, e_r1rdy, e_rs1b, e_rs2b, e_wen;
        logic            chk_w;
        logic [AW-1:0]   e_waddr;
        logic [XLEN-1:0] e_wdata;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic iv, input int ird, input int rs1, input int rs2,
                                input logic r0v, input int r0a, input logic [XLEN-1:0] r0d,
                                input logic r1v, input int r1a, input logic [XLEN-1:0] r1d,
                                input logic e0, input logic e1, input logic eb1, input logic eb2,
                                input logic ew, input logic cw, input int ea, input logic [XLEN-1:0] ed);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = AW'(ird); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2);
        v.r0v = r0v; v.r0a = AW'(r0a); v.r0d = r0d;
        v.r1v = r1v; v.r1a = AW'(r1a); v.r1d = r1d;
        v.e_r0rdy = e0; v.e_r1rdy = e1; v.e_rs1b = eb1; v.e_rs2b = eb2;
        v.e_wen = ew; v.chk_w = cw; v.e_waddr = AW'(ea); v.e_wdata = ed;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic r0v, input logic [AW-1:0] r0a, input logic [XLEN-1:0] r0d,
                         input logic r1v, input logic [AW-1:0] r1a, input logic [XLEN-1:0] r1d);
        reset = rst; issueValid = iv; issueRd = ird; rs1Addr = rs1; rs2Addr = rs2;
        req0Valid = r0v; req0Addr = r0a; req0Data = r0d;
        req1Valid = r1v; req1Addr = r1a; req1Data = r1d;
    endtask

    // Behavioural model state for the random phase
    bit              m_busy[NREG];
    int              m_last;
    logic            m_wen;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    bit              m_known;
    bit              pv[2];
    logic [AW-1:0]   pa[2];
    logic [XLEN-1:0] pd[2];

    initial begin
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #2;
        check("reset_wen", {63'd0, wen}, 64'd0);
        check("reset_waddr", {59'd0, wAddr}, 64'd0);
        check("reset_wdata", wData, 64'd0);
        check("reset_rdy0", {63'd0, req0Ready}, 64'd0);
        check("reset_rdy1", {63'd0, req1Ready}, 64'd0);
        for (int a = 0; a < NREG; a++) begin
            rs1Addr = AW'(a); rs2Addr = AW'(NREG - 1 - a);
            #0.1;
            check("reset_rs1busy", {63'd0, rs1Busy}, 64'd0);
            check("reset_rs2busy", {63'd0, rs2Busy}, 64'd0);
        end

        //               rst  iv  ird rs1 rs2 r0v r0a r0d        r1v r1a r1d     e0 e1 b1 b2 wen cw addr data
        vecs[0]  = mk(1'b0,1'b0,0, 5, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 1, 0, 64'd0);
        vecs[1]  = mk(1'b0,1'b1,5, 5, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 1, 0, 64'd0);
        vecs[2]  = mk(1'b0,1'b0,0, 5, 5, 1'b1,5, 64'hDEAD,  1'b0,0, 64'd0,  1, 0, 1, 1, 1, 1, 5, 64'hDEAD);
        vecs[3]  = mk(1'b0,1'b0,0, 5, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 1, 5, 64'hDEAD);
        vecs[4]  = mk(1'b1,1'b0,0, 0, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 1, 0, 64'd0);
        vecs[5]  = mk(1'b0,1'b0,0, 0, 0, 1'b1,1, 64'h11,    1'b1,2, 64'h22, 1, 0, 0, 0, 1, 1, 1, 64'h11);
        vecs[6]  = mk(1'b0,1'b0,0, 0, 0, 1'b1,1, 64'h11,    1'b1,2, 64'h22, 0, 1, 0, 0, 1, 1, 2, 64'h22);
        vecs[7]  = mk(1'b0,1'b0,0, 0, 0, 1'b1,1, 64'h11,    1'b1,2, 64'h22, 1, 0, 0, 0, 1, 1, 1, 64'h11);
        vecs[8]  = mk(1'b0,1'b0,0, 0, 0, 1'b1,1, 64'h11,    1'b1,2, 64'h22, 0, 1, 0, 0, 1, 1, 2, 64'h22);
        vecs[9]  = mk(1'b0,1'b1,7, 7, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 1, 2, 64'h22);
        vecs[10] = mk(1'b0,1'b1,7, 7, 0, 1'b0,0, 64'd0,     1'b1,7, 64'h77, 0, 1, 1, 0, 1, 1, 7, 64'h77);
        vecs[11] = mk(1'b0,1'b0,0, 7, 7, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 1, 1, 0, 1, 7, 64'h77);
        vecs[12] = mk(1'b0,1'b1,0, 0, 0, 1'b1,0, 64'h1234,  1'b0,0, 64'd0,  1, 0, 0, 0, 0, 0, 0, 64'd0);
        vecs[13] = mk(1'b0,1'b0,0, 0, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 0, 0, 64'd0);
        vecs[14] = mk(1'b0,1'b1,3, 3, 0, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 0, 0, 64'd0);
        vecs[15] = mk(1'b1,1'b0,0, 3, 0, 1'b0,0, 64'd0,     1'b1,3, 64'h33, 0, 1, 1, 0, 0, 1, 0, 64'd0);
        vecs[16] = mk(1'b0,1'b0,0, 3, 7, 1'b0,0, 64'd0,     1'b0,0, 64'd0,  0, 0, 0, 0, 0, 1, 0, 64'd0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ird, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].r0v, vecs[i].r0a, vecs[i].r0d, vecs[i].r1v, vecs[i].r1a, vecs[i].r1d);
            #2;
            check($sformatf("v%0d_rdy0", i), {63'd0, req0Ready}, {63'd0, vecs[i].e_r0rdy});
            check($sformatf("v%0d_rdy1", i), {63'd0, req1Ready}, {63'd0, vecs[i].e_r1rdy});
            check($sformatf("v%0d_rs1busy", i), {63'd0, rs1Busy}, {63'd0, vecs[i].e_rs1b});
            check($sformatf("v%0d_rs2busy", i), {63'd0, rs2Busy}, {63'd0, vecs[i].e_rs2b});
            @(posedge clock);
            #1;
            check($sformatf("v%0d_wen", i), {63'd0, wen}, {63'd0, vecs[i].e_wen});
            if (vecs[i].chk_w) begin
                check($sformatf("v%0d_waddr", i), {59'd0, wAddr}, {59'd0, vecs[i].e_waddr});
                check($sformatf("v%0d_wdata", i), wData, vecs[i].e_wdata);
            end
        end

        // Random phase: DUT was left in reset-equivalent state by vector 16's preceding reset.
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        m_last = 1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_known = 1'b1;
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic          rst, iv;
            logic [AW-1:0] ird, rs1, rs2;
            int            g;
            rst = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom_range(0, 2) != 0)) begin
                    pv[p] = 1'b1;
                    pa[p] = AW'($urandom_range(0, NREG - 1));
                    pd[p] = {$urandom, $urandom};
                end
            end
            iv  = ($urandom_range(0, 2) == 0);
            ird = AW'($urandom_range(0, NREG - 1));
            if (m_busy[ird]) iv = 1'b0;
            rs1 = AW'($urandom_range(0, NREG - 1));
            rs2 = AW'($urandom_range(0, NREG - 1));

            if (pv[0] && pv[1]) g = (m_last == 0) ? 1 : 0;
            else if (pv[0])     g = 0;
            else if (pv[1])     g = 1;
            else                g = -1;

            drive(rst, iv, ird, rs1, rs2, pv[0], pa[0], pd[0], pv[1], pa[1], pd[1]);
            #2;
            check("rnd_rdy0", {63'd0, req0Ready}, {63'd0, g == 0});
            check("rnd_rdy1", {63'd0, req1Ready}, {63'd0, g == 1});
            check("rnd_rs1busy", {63'd0, rs1Busy}, {63'd0, m_busy[rs1]});
            check("rnd_rs2busy", {63'd0, rs2Busy}, {63'd0, m_busy[rs2]});
            @(posedge clock);
            #1;

            if (rst) begin
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
                m_last = 1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_known = 1'b1;
                pv[0] = 1'b0; pv[1] = 1'b0;
            end else begin
                m_wen = 1'b0;
                if (g >= 0) begin
                    m_last = g;
                    pv[g]  = 1'b0;
                    m_busy[pa[g]] = 1'b0;
                    if (pa[g] != '0) begin
                        m_wen = 1'b1; m_waddr = pa[g]; m_wdata = pd[g]; m_known = 1'b1;
                    end else begin
                        m_known = 1'b0;
                    end
                end
                if (iv && ird != '0) m_busy[ird] = 1'b1;
            end
            check("rnd_wen", {63'd0, wen}, {63'd0, m_wen});
            if (m_known) begin
                check("rnd_waddr", {59'd0, wAddr}, {59'd0, m_waddr});
                check("rnd_wdata", wData, m_wdata);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
